// File: rtl/gate_level_21mux.sv
// rtl/gate_level_21mux.sv - gate-level 2:1 mux with optional registered output; GATE_LEVEL_21MUX_HOLD_EN adds a load enable
module gate_level_21mux #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
`ifdef GATE_LEVEL_21MUX_HOLD_EN
    input  logic             en,
`endif
    output logic [WIDTH-1:0] y,
    output logic             y_sel
);

    logic             nsel;
    logic [WIDTH-1:0] t0;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] m;
    logic             load;

`ifdef GATE_LEVEL_21MUX_HOLD_EN
    assign load = en;
`else
    assign load = 1'b1;
`endif

    not u_nsel (nsel, sel);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and u_t0 (t0[i], a[i], nsel);
        and u_t1 (t1[i], b[i], sel);
        or  u_m  (m[i], t0[i], t1[i]);
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] y_q;
        logic             y_sel_q;

        // Reset wins over the hold enable so a held output can always be cleared.
        always_ff @(posedge clk) begin
            if (rst) begin
                y_q     <= '0;
                y_sel_q <= 1'b0;
            end else if (load) begin
                y_q     <= m;
                y_sel_q <= sel;
            end
        end

        assign y     = y_q;
        assign y_sel = y_sel_q;
    end else begin : g_comb
        assign y     = m;
        assign y_sel = sel;
    end

endmodule

// File: tb/tb_gate_level_21mux.sv
// tb/tb_gate_level_21mux.sv - self-checking bench for gate_level_21mux (registered and combinational builds)
module tb_gate_level_21mux;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, sel1, y1, ysel1;
    logic [7:0] a8, b8, y8;
    logic       sel8, ysel8;
    logic [3:0] a4, b4, y4;
    logic       sel4, ysel4;
`ifdef GATE_LEVEL_21MUX_HOLD_EN
    logic       en1, en8, en4;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gate_level_21mux #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1),
`ifdef GATE_LEVEL_21MUX_HOLD_EN
        .en(en1),
`endif
        .y(y1), .y_sel(ysel1));

    gate_level_21mux #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel8),
`ifdef GATE_LEVEL_21MUX_HOLD_EN
        .en(en8),
`endif
        .y(y8), .y_sel(ysel8));

    gate_level_21mux #(.WIDTH(4), .REG_OUT(1'b0)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .sel(sel4),
`ifdef GATE_LEVEL_21MUX_HOLD_EN
        .en(en4),
`endif
        .y(y4), .y_sel(ysel4));

    typedef struct {
        logic sel;
        logic a;
        logic b;
        logic y;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: registered mux is "previous edge's choice", cleared by reset.
    function automatic logic [7:0] ref_mux8(input logic r, input logic s, input logic [7:0] x, input logic [7:0] z);
        if (r) return 8'h00;
        return s ? z : x;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; sel1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; sel8 = 1'b1;
        a4 = 4'h0; b4 = 4'h0; sel4 = 1'b0;
`ifdef GATE_LEVEL_21MUX_HOLD_EN
        en1 = 1'b1; en8 = 1'b1; en4 = 1'b1;
`endif

        // Reset held two cycles with all-ones inputs
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_y1", y1, 0);
            check("rst_ysel1", ysel1, 0);
            check("rst_y8", y8, 8'h00);
        end
        rst = 1'b0;

        // Full truth table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            sel1 = tbl[i].sel; a1 = tbl[i].a; b1 = tbl[i].b;
            tick();
            check($sformatf("tt_y_%0d", i), y1, tbl[i].y);
            check($sformatf("tt_ysel_%0d", i), ysel1, tbl[i].sel);
        end

        // Alternating select, one-cycle lag, no bubble
        a8 = 8'hA5; b8 = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            sel8 = i[0];
            tick();
            check($sformatf("alt_y_%0d", i), y8, i[0] ? 8'h3C : 8'hA5);
            check($sformatf("alt_ysel_%0d", i), ysel8, i[0]);
        end

        // Reset mid-operation with a=FF, b=00, sel=1
        a8 = 8'hFF; b8 = 8'h00; sel8 = 1'b1;
        tick(); check("mid_c1", y8, 8'h00);
        tick(); check("mid_c2", y8, 8'h00);
        rst = 1'b1;
        tick(); check("mid_rst", y8, 8'h00);
        rst = 1'b0;
        tick(); check("mid_post", y8, 8'h00);
        sel8 = 1'b0;
        tick(); check("mid_sel0", y8, 8'hFF);
        check("mid_sel0_ysel", ysel8, 0);

        // Reset asserted between edges changes nothing until the edge; edge inputs are discarded
        a8 = 8'h5A;
        rst = 1'b1;
        #2;
        check("sync_only_y", y8, 8'hFF);
        tick(); check("rst_discard_y", y8, 8'h00);
        check("rst_discard_ysel", ysel8, 0);
        rst = 1'b0;
        tick(); check("rst_release_load", y8, 8'h5A);

        // a == b: output independent of sel
        a8 = 8'h77; b8 = 8'h77;
        for (int i = 0; i < 2; i++) begin
            sel8 = i[0];
            tick();
            check($sformatf("aeqb_%0d", i), y8, 8'h77);
        end

        // Combinational build follows immediately; reset does not clear it
        a4 = 4'h9; b4 = 4'h6;
        for (int i = 0; i < 4; i++) begin
            sel4 = i[0];
            #1;
            check($sformatf("comb_y_%0d", i), y4, i[0] ? 4'h6 : 4'h9);
            check($sformatf("comb_ysel_%0d", i), ysel4, i[0]);
        end
        rst = 1'b1;
        tick();
        check("comb_rst_y", y4, 4'h6);
        rst = 1'b0;
        tick();

`ifdef GATE_LEVEL_21MUX_HOLD_EN
        a8 = 8'h12; sel8 = 1'b0; en8 = 1'b1;
        tick(); check("hold_load", y8, 8'h12);
        a8 = 8'h34; en8 = 1'b0;
        tick(); check("hold_keep", y8, 8'h12);
        rst = 1'b1;
        tick(); check("hold_rst", y8, 8'h00);
        rst = 1'b0; en8 = 1'b1;
        tick(); check("hold_reload", y8, 8'h34);
`endif

        // Randomised run against the reference
        for (int i = 0; i < 200; i++) begin
            logic       r, s;
            logic [7:0] x, z;
            logic [3:0] x4, z4;
            logic       s4;
            r  = ($urandom_range(0, 7) == 0);
            s  = $urandom_range(0, 1);
            x  = 8'($urandom);
            z  = 8'($urandom);
            x4 = 4'($urandom);
            z4 = 4'($urandom);
            s4 = $urandom_range(0, 1);
            rst = r; sel8 = s; a8 = x; b8 = z;
            a4 = x4; b4 = z4; sel4 = s4;
            tick();
            check($sformatf("rnd_y8_%0d", i), y8, ref_mux8(r, s, x, z));
            check($sformatf("rnd_ysel8_%0d", i), ysel8, r ? 1'b0 : s);
            check($sformatf("rnd_y4_%0d", i), y4, s4 ? z4 : x4);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
